code_mux8to1: RTL and testbench
===============================

// Module: code_mux8to1
// PURPOSE
//  - Registered 8-to-1 single-bit multiplexer: Y = I[Sel], captured on the clock edge.
//  - Also gives an unregistered tap, a valid pipeline flag and an out-of-range select flag.
//  - Leaf datapath block used wherever one lane of a bit vector is picked by an index.
// PARAMETERS
//  - NUM_IN   8   number of data inputs; legal range 2..256.
//  - SEL_W    3   select width; must equal $clog2(NUM_IN).
//  - RST_VAL  1'b0   reset value of Y.
// PORTS
//  - clk      in   1        rising-edge clock; the only clock domain.
//  - rst      in   1        reset; synchronous and active-high.
//  - I        in   NUM_IN   data inputs; I[k] is lane k.
//  - Sel      in   SEL_W    lane index (binary, unsigned).
//  - in_vld   in   1        qualifies I/Sel this cycle.
//  - Y        out  1        registered selected bit.
//  - Y_comb   out  1        combinational selected bit, same cycle as I/Sel.
//  - out_vld  out  1        Y holds a result from a qualified input.
//  - sel_err  out  1        registered: last qualified Sel was >= NUM_IN.
// BEHAVIOUR
//  - Selection rule:
//    - Y_comb = I[Sel] when Sel < NUM_IN.
//    - Y_comb = 0 when Sel >= NUM_IN (possible only if NUM_IN is not a power of 2).
//    - X/Z on Sel must not propagate through a priority chain; use a pure index/tree mux.
//  - Reset: when rst=1 at a posedge -> Y=RST_VAL, out_vld=0, sel_err=0. Y_comb stays combinational.
//  - Latency: 1 clock from I/Sel to Y. Y_comb has 0 latency.
//  - Update on posedge, rst=0, in_vld=1: Y <= Y_comb; out_vld <= 1; sel_err <= (Sel >= NUM_IN).
//  - Hold on posedge, rst=0, in_vld=0: Y and sel_err hold; out_vld <= 0.
//  - No backpressure: a new selection is accepted every cycle.
//  - Reset together with in_vld=1: reset wins and the input is dropped.
//  - Reset mid-stream: the next cycle's qualified input is accepted normally.
//  - Changing I or Sel between edges affects only Y_comb; Y changes only at a clock edge.
//  - Boundary lanes: Sel=0 and Sel=NUM_IN-1 must select exactly I[0] and I[NUM_IN-1].
//  - No internal state other than the three output registers.
// STRUCTURE
//  - Shared package code_mux_pkg: default NUM_IN, SEL_W and RST_VAL constants, and a function
//    sel_in_range(sel, n).
//  - One combinational sub-module, mux_tree_n, built as a log2 binary tree of 2:1 muxes.
//    - Ports: I, Sel -> Y_comb. Parameterised by NUM_IN.
//  - The top level holds mux_tree_n, the range check and the output registers.
// TESTING
//  - Reset: rst=1 for 2 clocks, I=8'hFF, Sel=7 -> Y=0, out_vld=0, sel_err=0. Y_comb=1.
//  - Directed vectors with in_vld=1; each Y is checked one clock after it is applied:
//    - I=8'b00010011, Sel=4 -> Y=1
//    - I=8'b00000001, Sel=1 -> Y=0
//    - I=8'b00000010, Sel=2 -> Y=0
//    - I=8'b00000010, Sel=1 -> Y=1
//    - I=8'b00000100, Sel=2 -> Y=1
//    - I=8'b00001001, Sel=4 -> Y=0
//    - I=8'b00100001, Sel=5 -> Y=1
//    - I=8'b10100001, Sel=7 -> Y=1
//    - I=8'b10100001, Sel=1 -> Y=0
//  - Latency/hold: apply I=8'h80, Sel=7, then drop in_vld -> Y=1 one clock later, Y holds 1,
//    out_vld pulses for 1 cycle.
//  - Walking one: I=1<<k and Sel=j for all k,j in 0..7 -> Y=(k==j). Y_comb matches in the same cycle.
//  - Reset collision: rst=1 and in_vld=1 with I=8'hFF, Sel=0 -> Y=0, out_vld=0.
//  - Non-power-of-2 build NUM_IN=6, SEL_W=3: Sel=6, I=6'h3F -> Y_comb=0; after the clock Y=0
//    and sel_err=1.

Source files
------------

// File: rtl/code_mux_pkg.sv
// Shared constants and helpers for the registered lane-select multiplexer.
//   DEF_NUM_IN   default number of data lanes
//   DEF_SEL_W    default select width, equal to $clog2(DEF_NUM_IN)
//   DEF_RST_VAL  default reset value of the registered output
//   sel_in_range returns 1 when a lane index addresses a real lane
package code_mux_pkg;

  localparam int   DEF_NUM_IN  = 8;
  localparam int   DEF_SEL_W   = 3;
  localparam logic DEF_RST_VAL = 1'b0;

  // Lane indices at or above the lane count only exist when the lane count
  // is not a power of two; those selections read as zero and raise sel_err.
  function automatic logic sel_in_range(input int sel, input int n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/mux_tree_n.sv
// Combinational N-to-1 single-bit multiplexer built as a binary tree of 2:1
// muxes, one tree level per select bit.
//   I       in   NUM_IN  data lanes, I[k] is lane k
//   Sel     in   SEL_W   unsigned lane index
//   Y_comb  out  1       I[Sel], or 0 when Sel addresses a lane beyond NUM_IN
module mux_tree_n
  import code_mux_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] I,
  input  logic [SEL_W-1:0]  Sel,
  output logic              Y_comb
);

  localparam int LEAVES = 1 << SEL_W;

  // Heap-ordered node array: node 0 is the root, node i has children 2i+1
  // (select bit 0) and 2i+2 (select bit 1), leaves start at LEAVES-1. Walking
  // from root to leaf consumes Sel from MSB to LSB, so leaf LEAVES-1+k is lane k.
  logic [2*LEAVES-2:0] node;

  // Leaves past the last real lane are tied low so out-of-range selections
  // yield 0 without any separate range gating.
  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < NUM_IN) begin : g_real
      assign node[LEAVES-1+k] = I[k];
    end else begin : g_pad
      assign node[LEAVES-1+k] = 1'b0;
    end
  end

  for (genvar d = 0; d < SEL_W; d++) begin : g_level
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      localparam int IDX = (1 << d) - 1 + j;
      assign node[IDX] = Sel[SEL_W-1-d] ? node[2*IDX+2] : node[2*IDX+1];
    end
  end

  assign Y_comb = node[0];

endmodule

// File: rtl/code_mux8to1.sv
// Registered lane-select multiplexer: Y is I[Sel] captured on the rising clock
// edge when the inputs are qualified, alongside a zero-latency tap.
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous active-high reset
//   I        in   NUM_IN  data lanes
//   Sel      in   SEL_W   unsigned lane index
//   in_vld   in   1       qualifies I/Sel this cycle
//   Y        out  1       registered selected bit
//   Y_comb   out  1       combinational selected bit
//   out_vld  out  1       Y was loaded from a qualified input last edge
//   sel_err  out  1       last qualified Sel addressed a lane >= NUM_IN
module code_mux8to1
  import code_mux_pkg::*;
#(
  parameter int   NUM_IN  = DEF_NUM_IN,
  parameter int   SEL_W   = DEF_SEL_W,
  parameter logic RST_VAL = DEF_RST_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] I,
  input  logic [SEL_W-1:0]  Sel,
  input  logic              in_vld,
  output logic              Y,
  output logic              Y_comb,
  output logic              out_vld,
  output logic              sel_err
);

  logic y_q, y_d;
  logic outVld_q, outVld_d;
  logic selErr_q, selErr_d;
  logic selOutOfRange;

  mux_tree_n #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_tree (
    .I      (I),
    .Sel    (Sel),
    .Y_comb (Y_comb)
  );

  assign selOutOfRange = !sel_in_range(int'(Sel), NUM_IN);

  // Y and sel_err only move on a qualified input; out_vld simply follows
  // in_vld so it pulses for exactly one cycle per accepted selection.
  always_comb begin
    y_d      = y_q;
    selErr_d = selErr_q;
    outVld_d = in_vld;
    if (in_vld) begin
      y_d      = Y_comb;
      selErr_d = selOutOfRange;
    end
  end

  // Reset takes priority over a qualified input arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= RST_VAL;
      outVld_q <= 1'b0;
      selErr_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      outVld_q <= outVld_d;
      selErr_q <= selErr_d;
    end
  end

  assign Y       = y_q;
  assign out_vld = outVld_q;
  assign sel_err = selErr_q;

endmodule

// File: tb/tb_code_mux8to1.sv
// Testbench for code_mux8to1: one 8-lane instance and one 6-lane instance
// sharing clock and reset, checked through an expected-result queue.
module tb_code_mux8to1;

  logic       clk;
  logic       rst;

  logic [7:0] dataIn;
  logic [2:0] sel;
  logic       inVld;
  logic       y, yComb, outVld, selErr;

  logic [5:0] dataIn6;
  logic [2:0] sel6;
  logic       inVld6;
  logic       y6, yComb6, outVld6, selErr6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit    lane6;
    logic  y;
    logic  vld;
    logic  err;
    string tag;
  } exp_t;

  exp_t sbQ[$];

  // Expected register state per instance (index 0: 8 lanes, 1: 6 lanes).
  logic mY   [2];
  logic mVld [2];
  logic mErr [2];

  logic [7:0] dirI   [9] = '{8'b00010011, 8'b00000001, 8'b00000010, 8'b00000010, 8'b00000100,
                             8'b00001001, 8'b00100001, 8'b10100001, 8'b10100001};
  logic [2:0] dirSel [9] = '{3'd4, 3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd1};
  logic       dirY   [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  code_mux8to1 dut (
    .clk     (clk),
    .rst     (rst),
    .I       (dataIn),
    .Sel     (sel),
    .in_vld  (inVld),
    .Y       (y),
    .Y_comb  (yComb),
    .out_vld (outVld),
    .sel_err (selErr)
  );

  code_mux8to1 #(
    .NUM_IN  (6),
    .SEL_W   (3),
    .RST_VAL (1'b0)
  ) dut6 (
    .clk     (clk),
    .rst     (rst),
    .I       (dataIn6),
    .Sel     (sel6),
    .in_vld  (inVld6),
    .Y       (y6),
    .Y_comb  (yComb6),
    .out_vld (outVld6),
    .sel_err (selErr6)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against the run stalling.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge, checks the
  // combinational tap immediately, queues the registered result and checks
  // it just after the following rising edge.
  task automatic applyStimulus(input bit lane6, input logic [7:0] iv, input logic [2:0] sv,
                               input logic vld, input logic rv, input logic expComb,
                               input string tag);
    exp_t e;
    exp_t got;
    int   t;
    int   n;
    t = lane6 ? 1 : 0;
    n = lane6 ? 6 : 8;
    @(negedge clk);
    rst = rv;
    if (lane6) begin
      dataIn6 = iv[5:0];
      sel6    = sv;
      inVld6  = vld;
      inVld   = 1'b0;
    end else begin
      dataIn  = iv;
      sel     = sv;
      inVld   = vld;
      inVld6  = 1'b0;
    end
    #1;
    checkOutput({tag, ".comb"}, lane6 ? yComb6 : yComb, expComb);

    if (rv) begin
      for (int i = 0; i < 2; i++) begin
        mY[i]   = 1'b0;
        mVld[i] = 1'b0;
        mErr[i] = 1'b0;
      end
    end else begin
      mVld[0] = 1'b0;
      mVld[1] = 1'b0;
      if (vld) begin
        mY[t]   = expComb;
        mVld[t] = 1'b1;
        mErr[t] = (int'(sv) >= n);
      end
    end
    e.lane6 = lane6;
    e.y     = mY[t];
    e.vld   = mVld[t];
    e.err   = mErr[t];
    e.tag   = tag;
    sbQ.push_back(e);

    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.queue: got empty expected entry", tag);
    end else begin
      got = sbQ.pop_front();
      checkOutput({got.tag, ".y"},   got.lane6 ? y6 : y,             got.y);
      checkOutput({got.tag, ".vld"}, got.lane6 ? outVld6 : outVld,   got.vld);
      checkOutput({got.tag, ".err"}, got.lane6 ? selErr6 : selErr,   got.err);
    end
  endtask

  initial begin
    rst     = 1'b1;
    dataIn  = 8'hFF;
    sel     = 3'd7;
    inVld   = 1'b0;
    dataIn6 = 6'h00;
    sel6    = 3'd0;
    inVld6  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mY[i]   = 1'b0;
      mVld[i] = 1'b0;
      mErr[i] = 1'b0;
    end

    // Reset held for two clocks with all lanes high and the top lane selected.
    applyStimulus(1'b0, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1, "reset0");
    applyStimulus(1'b0, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1, "reset1");

    for (int i = 0; i < 9; i++)
      applyStimulus(1'b0, dirI[i], dirSel[i], 1'b1, 1'b0, dirY[i], $sformatf("dir%0d", i));

    // One-cycle latency, then hold while the inputs change underneath.
    applyStimulus(1'b0, 8'h80, 3'd7, 1'b1, 1'b0, 1'b1, "latency");
    applyStimulus(1'b0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, "hold0");
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "hold1");

    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++)
        applyStimulus(1'b0, 8'(1 << k), 3'(j), 1'b1, 1'b0, (k == j),
                      $sformatf("walk_k%0d_s%0d", k, j));

    // Load a 1 so the colliding reset visibly clears it, then resume.
    applyStimulus(1'b0, 8'hFF, 3'd3, 1'b1, 1'b0, 1'b1, "preload");
    applyStimulus(1'b0, 8'hFF, 3'd0, 1'b1, 1'b1, 1'b1, "rstCollide");
    applyStimulus(1'b0, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b1, "afterReset");

    // Six-lane instance: boundary lanes, out-of-range selects and hold of sel_err.
    applyStimulus(1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 1'b1, "n6_top");
    applyStimulus(1'b1, 8'h3F, 3'd6, 1'b1, 1'b0, 1'b0, "n6_sel6");
    applyStimulus(1'b1, 8'h20, 3'd5, 1'b0, 1'b0, 1'b1, "n6_hold");
    applyStimulus(1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1, "n6_bot");
    applyStimulus(1'b1, 8'h3F, 3'd7, 1'b1, 1'b0, 1'b0, "n6_sel7");
    applyStimulus(1'b1, 8'h1F, 3'd4, 1'b1, 1'b0, 1'b1, "n6_lane4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
